// File: rtl/retire_trace_checker.sv
// -----------------------------------------------------------------------------
// retire_trace_checker
//
// Lockstep retirement comparator for a dual-core equivalence environment.
// Channel A (sequential core) and channel B (pipelined core) each push their
// retirement records into a private FIFO. Whenever both FIFOs hold a record,
// the two heads are popped together and compared. Any divergence, a push into
// a full FIFO, or one core running too far ahead of the other stops checking
// (HALT) until clear or reset.
//
// Optional feature macro: RETIRE_CHK_X0_FILTER_EN
//   defined   - a head record with we=1 and rd=0 is compared as if we=0
//   undefined - we/rd/wdata are compared literally
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   clear                synchronous clear of FIFOs, flags and counters
//   a_* / b_*            retirement record strobe and fields per channel
//   mismatch             sticky, first compared pair diverged
//   mismatch_cause       {writeback, instr, pc} failing fields of that pair
//   first_bad_pc         channel A pc of that pair
//   overflow             sticky, record dropped on a full FIFO
//   timeout              sticky, one FIFO waited TIMEOUT cycles alone
//   halted               checker stopped
//   checked_cnt          matched pairs, saturating
//   a_level, b_level     FIFO occupancy
// -----------------------------------------------------------------------------
module retire_trace_checker #(
    parameter int  XLEN    = 32,
    parameter int  DEPTH   = 8,
    parameter int  TIMEOUT = 64,
    parameter int  CNT_W   = 16,
    localparam int LVL_W   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             a_valid,
    input  logic [XLEN-1:0]  a_pc,
    input  logic [31:0]      a_instr,
    input  logic             a_we,
    input  logic [4:0]       a_rd,
    input  logic [XLEN-1:0]  a_wdata,
    input  logic             b_valid,
    input  logic [XLEN-1:0]  b_pc,
    input  logic [31:0]      b_instr,
    input  logic             b_we,
    input  logic [4:0]       b_rd,
    input  logic [XLEN-1:0]  b_wdata,
    output logic             mismatch,
    output logic [2:0]       mismatch_cause,
    output logic [XLEN-1:0]  first_bad_pc,
    output logic             overflow,
    output logic             timeout,
    output logic             halted,
    output logic [CNT_W-1:0] checked_cnt,
    output logic [LVL_W-1:0] a_level,
    output logic [LVL_W-1:0] b_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(TIMEOUT + 1);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            we;
        logic [4:0]      rd;
        logic [XLEN-1:0] wdata;
    } rec_t;

    rec_t             a_mem_q [DEPTH];
    rec_t             b_mem_q [DEPTH];

    logic [0:0]       state_q, state_d;
    logic [AW-1:0]    a_wp_q, a_wp_d, a_rp_q, a_rp_d;
    logic [AW-1:0]    b_wp_q, b_wp_d, b_rp_q, b_rp_d;
    logic [LVL_W-1:0] a_lvl_q, a_lvl_d, b_lvl_q, b_lvl_d;
    logic [SW-1:0]    skew_q, skew_d;
    logic             mismatch_q, mismatch_d;
    logic             overflow_q, overflow_d;
    logic             timeout_q, timeout_d;
    logic [2:0]       cause_q, cause_d;
    logic [XLEN-1:0]  bad_pc_q, bad_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    rec_t             a_in, b_in, a_head, b_head;
    logic             run, a_ne, b_ne, a_full, b_full;
    logic             pop, a_push, b_push, a_drop, b_drop, skew_hit;
    logic             a_we_eff, b_we_eff;
    logic [2:0]       cause_now;

    assign a_in   = {a_pc, a_instr, a_we, a_rd, a_wdata};
    assign b_in   = {b_pc, b_instr, b_we, b_rd, b_wdata};
    assign a_head = a_mem_q[a_rp_q];
    assign b_head = b_mem_q[b_rp_q];

    // clear wins over everything, so every action below is gated by it.
    assign run    = (state_q == ST_RUN) && !clear;
    assign a_ne   = (a_lvl_q != '0);
    assign b_ne   = (b_lvl_q != '0);
    assign a_full = (a_lvl_q == LVL_W'(DEPTH));
    assign b_full = (b_lvl_q == LVL_W'(DEPTH));
    assign pop    = run && a_ne && b_ne;

    // A same-cycle pop frees a slot, so a full FIFO still accepts the push.
    assign a_push = run && a_valid && (!a_full || pop);
    assign b_push = run && b_valid && (!b_full || pop);
    assign a_drop = run && a_valid && a_full && !pop;
    assign b_drop = run && b_valid && b_full && !pop;

    // Exactly one FIFO occupied implies no pop this cycle.
    assign skew_hit = run && (a_ne != b_ne) && (skew_q == SW'(TIMEOUT - 1));

    // Head comparison; only consumed when pop is high.
    always_comb begin
        // NOTE: every variable gets a value before any condition, so no latch can be inferred.
        a_we_eff = a_head.we;
        b_we_eff = b_head.we;
`ifdef RETIRE_CHK_X0_FILTER_EN
        // x0 writes are architecturally invisible; compare them as no write.
        if (a_head.rd == 5'd0) a_we_eff = 1'b0;
        if (b_head.rd == 5'd0) b_we_eff = 1'b0;
`endif
        cause_now[0] = (a_head.pc != b_head.pc);
        cause_now[1] = (a_head.instr != b_head.instr);
        cause_now[2] = (a_we_eff != b_we_eff) ||
                       (a_we_eff && ((a_head.rd != b_head.rd) || (a_head.wdata != b_head.wdata)));
    end

    // NOTE: record storage is deliberately not reset; pointers and levels decide which entries are live.
    always_ff @(posedge clk) begin
        if (a_push) a_mem_q[a_wp_q] <= a_in;
        if (b_push) b_mem_q[b_wp_q] <= b_in;
    end

    always_comb begin
        state_d    = state_q;
        a_wp_d     = a_wp_q;
        a_rp_d     = a_rp_q;
        b_wp_d     = b_wp_q;
        b_rp_d     = b_rp_q;
        a_lvl_d    = a_lvl_q;
        b_lvl_d    = b_lvl_q;
        skew_d     = skew_q;
        mismatch_d = mismatch_q;
        overflow_d = overflow_q;
        timeout_d  = timeout_q;
        cause_d    = cause_q;
        bad_pc_d   = bad_pc_q;
        cnt_d      = cnt_q;

        if (clear) begin
            state_d    = ST_RUN;
            a_wp_d     = '0;
            a_rp_d     = '0;
            b_wp_d     = '0;
            b_rp_d     = '0;
            a_lvl_d    = '0;
            b_lvl_d    = '0;
            skew_d     = '0;
            mismatch_d = 1'b0;
            overflow_d = 1'b0;
            timeout_d  = 1'b0;
            cause_d    = '0;
            bad_pc_d   = '0;
            cnt_d      = '0;
        end else if (state_q == ST_RUN) begin
            if (a_push) a_wp_d = a_wp_q + AW'(1);
            if (b_push) b_wp_d = b_wp_q + AW'(1);
            if (pop) begin
                a_rp_d = a_rp_q + AW'(1);
                b_rp_d = b_rp_q + AW'(1);
            end
            a_lvl_d = a_lvl_q + LVL_W'(a_push) - LVL_W'(pop);
            b_lvl_d = b_lvl_q + LVL_W'(b_push) - LVL_W'(pop);

            if (pop || (!a_ne && !b_ne)) skew_d = '0;
            else                         skew_d = skew_q + SW'(1);

            if (pop) begin
                if (cause_now != 3'b000) begin
                    mismatch_d = 1'b1;
                    cause_d    = cause_now;
                    bad_pc_d   = a_head.pc;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            if (a_drop || b_drop) overflow_d = 1'b1;
            if (skew_hit)         timeout_d  = 1'b1;

            if (a_drop || b_drop || skew_hit || (pop && (cause_now != 3'b000)))
                state_d = ST_HALT;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_RUN;
            a_wp_q     <= '0;
            a_rp_q     <= '0;
            b_wp_q     <= '0;
            b_rp_q     <= '0;
            a_lvl_q    <= '0;
            b_lvl_q    <= '0;
            skew_q     <= '0;
            mismatch_q <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            cause_q    <= '0;
            bad_pc_q   <= '0;
            cnt_q      <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all of them update from the same pre-edge values.
            state_q    <= state_d;
            a_wp_q     <= a_wp_d;
            a_rp_q     <= a_rp_d;
            b_wp_q     <= b_wp_d;
            b_rp_q     <= b_rp_d;
            a_lvl_q    <= a_lvl_d;
            b_lvl_q    <= b_lvl_d;
            skew_q     <= skew_d;
            mismatch_q <= mismatch_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
            cause_q    <= cause_d;
            bad_pc_q   <= bad_pc_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mismatch       = mismatch_q;
    assign mismatch_cause = cause_q;
    assign first_bad_pc   = bad_pc_q;
    assign overflow       = overflow_q;
    assign timeout        = timeout_q;
    assign halted         = (state_q == ST_HALT);
    assign checked_cnt    = cnt_q;
    assign a_level        = a_lvl_q;
    assign b_level        = b_lvl_q;

endmodule

// File: tb/tb_retire_trace_checker.sv
// -----------------------------------------------------------------------------
// tb_retire_trace_checker
//
// Directed scenarios with literal expectations, followed by randomized
// segments. A queue-based model of the checker runs alongside and every
// output is compared against it on each falling clock edge.
// -----------------------------------------------------------------------------
module tb_retire_trace_checker;

    localparam int XLEN    = 32;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 16;
    localparam int LVL_W   = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wdata;
    } trec_t;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             clear = 1'b0;
    logic             a_valid = 1'b0;
    logic [31:0]      a_pc = '0;
    logic [31:0]      a_instr = '0;
    logic             a_we = 1'b0;
    logic [4:0]       a_rd = '0;
    logic [31:0]      a_wdata = '0;
    logic             b_valid = 1'b0;
    logic [31:0]      b_pc = '0;
    logic [31:0]      b_instr = '0;
    logic             b_we = 1'b0;
    logic [4:0]       b_rd = '0;
    logic [31:0]      b_wdata = '0;
    logic             mismatch;
    logic [2:0]       mismatch_cause;
    logic [31:0]      first_bad_pc;
    logic             overflow;
    logic             timeout;
    logic             halted;
    logic [CNT_W-1:0] checked_cnt;
    logic [LVL_W-1:0] a_level;
    logic [LVL_W-1:0] b_level;

    retire_trace_checker #(
        .XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .resetn(resetn), .clear(clear),
        .a_valid(a_valid), .a_pc(a_pc), .a_instr(a_instr), .a_we(a_we), .a_rd(a_rd), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_pc(b_pc), .b_instr(b_instr), .b_we(b_we), .b_rd(b_rd), .b_wdata(b_wdata),
        .mismatch(mismatch), .mismatch_cause(mismatch_cause), .first_bad_pc(first_bad_pc),
        .overflow(overflow), .timeout(timeout), .halted(halted), .checked_cnt(checked_cnt),
        .a_level(a_level), .b_level(b_level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------------------------------------------------------- model
    trec_t       qa[$];
    trec_t       qb[$];
    logic        m_mis  = 1'b0;
    logic        m_ovf  = 1'b0;
    logic        m_to   = 1'b0;
    logic        m_halt = 1'b0;
    logic [2:0]  m_cause = '0;
    logic [31:0] m_fbpc  = '0;
    int          m_cnt  = 0;
    int          m_skew = 0;

    function automatic logic [2:0] rule_cmp(input trec_t a, input trec_t b);
        logic [2:0] c;
        logic awe;
        logic bwe;
        awe = a.we;
        bwe = b.we;
`ifdef RETIRE_CHK_X0_FILTER_EN
        if (a.rd == 5'd0) awe = 1'b0;
        if (b.rd == 5'd0) bwe = 1'b0;
`endif
        c[0] = (a.pc != b.pc);
        c[1] = (a.instr != b.instr);
        if (!awe && !bwe)     c[2] = 1'b0;
        else if (awe != bwe)  c[2] = 1'b1;
        else                  c[2] = (a.rd != b.rd) || (a.wdata != b.wdata);
        return c;
    endfunction

    function automatic trec_t mk(input logic [31:0] pc, input logic [31:0] instr,
                                 input logic we, input logic [4:0] rd, input logic [31:0] wd);
        trec_t r;
        r.pc = pc; r.instr = instr; r.we = we; r.rd = rd; r.wdata = wd;
        return r;
    endfunction

    // Inputs change just after the falling edge, so at the falling edge they
    // still hold what the preceding rising edge sampled: advance the model
    // with them, then compare.
    always @(negedge clk) begin : model_and_compare
        int na;
        int nb;
        trec_t ha;
        trec_t hb;
        logic [2:0] c;
        if (!resetn || clear) begin
            qa.delete();
            qb.delete();
            m_mis = 1'b0; m_ovf = 1'b0; m_to = 1'b0; m_halt = 1'b0;
            m_cause = '0; m_fbpc = '0; m_cnt = 0; m_skew = 0;
        end else if (!m_halt) begin
            na = qa.size();
            nb = qb.size();
            if (na > 0 && nb > 0) begin
                ha = qa.pop_front();
                hb = qb.pop_front();
                c  = rule_cmp(ha, hb);
                if (c != 3'b000) begin
                    m_mis = 1'b1; m_cause = c; m_fbpc = ha.pc; m_halt = 1'b1;
                end else if (m_cnt < (2**CNT_W) - 1) begin
                    m_cnt++;
                end
                m_skew = 0;
            end else if (na == 0 && nb == 0) begin
                m_skew = 0;
            end else begin
                m_skew++;
                if (m_skew == TIMEOUT) begin
                    m_to = 1'b1; m_halt = 1'b1;
                end
            end
            if (a_valid) begin
                if (qa.size() < DEPTH) qa.push_back(mk(a_pc, a_instr, a_we, a_rd, a_wdata));
                else begin m_ovf = 1'b1; m_halt = 1'b1; end
            end
            if (b_valid) begin
                if (qb.size() < DEPTH) qb.push_back(mk(b_pc, b_instr, b_we, b_rd, b_wdata));
                else begin m_ovf = 1'b1; m_halt = 1'b1; end
            end
        end
        check("mdl_mismatch", 64'(mismatch),       64'(m_mis));
        check("mdl_cause",    64'(mismatch_cause), 64'(m_cause));
        check("mdl_bad_pc",   64'(first_bad_pc),   64'(m_fbpc));
        check("mdl_overflow", 64'(overflow),       64'(m_ovf));
        check("mdl_timeout",  64'(timeout),        64'(m_to));
        check("mdl_halted",   64'(halted),         64'(m_halt));
        check("mdl_cnt",      64'(checked_cnt),    64'(m_cnt));
        check("mdl_a_level",  64'(a_level),        64'(qa.size()));
        check("mdl_b_level",  64'(b_level),        64'(qb.size()));
    end

    // ------------------------------------------------------------ stimulus
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input trec_t ar, input logic bv, input trec_t br);
        a_valid = av; a_pc = ar.pc; a_instr = ar.instr; a_we = ar.we; a_rd = ar.rd; a_wdata = ar.wdata;
        b_valid = bv; b_pc = br.pc; b_instr = br.instr; b_we = br.we; b_rd = br.rd; b_wdata = br.wdata;
    endtask

    task automatic idle();
        drive(1'b0, mk('0, '0, 1'b0, '0, '0), 1'b0, mk('0, '0, 1'b0, '0, '0));
    endtask

    task automatic do_clear();
        idle();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    function automatic trec_t rand_rec();
        trec_t r;
        r.pc    = $urandom;
        r.instr = $urandom;
        r.we    = 1'($urandom_range(0, 1));
        r.rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        r.wdata = $urandom;
        return r;
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        trec_t ra;
        trec_t rb;
        trec_t prog[128];
        int    peak;
        int    k;
        int    ia;
        int    ib;
        int    pa;
        int    pb;
        logic  av;
        logic  bv;

        idle();
        tick();
        tick();
        resetn = 1'b1;
        tick();
        check("rst_mismatch", 64'(mismatch),    64'd0);
        check("rst_halted",   64'(halted),      64'd0);
        check("rst_cnt",      64'(checked_cnt), 64'd0);
        check("rst_a_level",  64'(a_level),     64'd0);

        // Identical 5-record streams retiring together.
        for (int i = 0; i < 5; i++) begin
            ra = mk(32'(i * 4), 32'h0011_0113, 1'b1, 5'd2, 32'(i));
            drive(1'b1, ra, 1'b1, ra);
            tick();
        end
        idle();
        tick();
        tick();
        check("t1_cnt",      64'(checked_cnt), 64'd5);
        check("t1_mismatch", 64'(mismatch),    64'd0);
        check("t1_flags",    64'({overflow, timeout, halted}), 64'd0);
        check("t1_levels",   64'({a_level, b_level}), 64'd0);

        // B retires the same 4 records 3 cycles after A.
        do_clear();
        peak = 0;
        for (int i = 0; i < 7; i++) begin
            ra = mk(32'h100 + 32'(i * 4), 32'h0020_0093, 1'b1, 5'd1, 32'(i + 10));
            rb = mk(32'h100 + 32'((i - 3) * 4), 32'h0020_0093, 1'b1, 5'd1, 32'(i + 7));
            drive(i < 4, ra, i >= 3, rb);
            tick();
            if (int'(a_level) > peak) peak = int'(a_level);
        end
        idle();
        repeat (3) tick();
        check("t2_a_peak",  64'(peak),        64'd4);
        check("t2_cnt",     64'(checked_cnt), 64'd4);
        check("t2_timeout", 64'(timeout),     64'd0);

        // Third pair differs only in writeback data.
        do_clear();
        for (int i = 0; i < 6; i++) begin
            ra = mk(32'h200 + 32'(i * 4), 32'h0041_8193, 1'b1, 5'd3, 32'h4);
            rb = ra;
            if (i == 2) rb.wdata = 32'h5;
            drive(1'b1, ra, 1'b1, rb);
            tick();
        end
        idle();
        tick();
        check("t3_mismatch", 64'(mismatch),       64'd1);
        check("t3_cause",    64'(mismatch_cause), 64'h4);
        check("t3_bad_pc",   64'(first_bad_pc),   64'h208);
        check("t3_halted",   64'(halted),         64'd1);
        check("t3_cnt",      64'(checked_cnt),    64'd2);
        check("t3_a_level",  64'(a_level),        64'd1);

        // A pushes 9 records, B idle.
        do_clear();
        for (int i = 0; i < 9; i++) begin
            ra = mk(32'h300 + 32'(i * 4), 32'h0000_0013, 1'b0, 5'd0, 32'h0);
            drive(1'b1, ra, 1'b0, ra);
            tick();
            if (i == 7) check("t4_ovf_before", 64'(overflow), 64'd0);
        end
        idle();
        check("t4_overflow", 64'(overflow), 64'd1);
        check("t4_halted",   64'(halted),   64'd1);
        check("t4_a_level",  64'(a_level),  64'd8);

        // A single A record with B silent: timeout after TIMEOUT cycles.
        do_clear();
        ra = mk(32'h400, 32'h0000_0013, 1'b0, 5'd0, 32'h0);
        drive(1'b1, ra, 1'b0, ra);
        tick();
        idle();
        k = 101;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (timeout) begin
                k = i;
                break;
            end
        end
        check("t5_timeout_cycles", 64'(k),      64'd64);
        check("t5_halted",         64'(halted), 64'd1);
        do_clear();
        check("t5_clr_flags",  64'({mismatch, mismatch_cause, overflow, timeout, halted}), 64'd0);
        check("t5_clr_pc",     64'(first_bad_pc), 64'd0);
        check("t5_clr_cnt",    64'(checked_cnt),  64'd0);
        check("t5_clr_levels", 64'({a_level, b_level}), 64'd0);

        // x0 writeback on A only.
        do_clear();
        ra = mk(32'h500, 32'h0070_0013, 1'b1, 5'd0, 32'h7);
        rb = mk(32'h500, 32'h0070_0013, 1'b0, 5'd0, 32'h0);
        drive(1'b1, ra, 1'b1, rb);
        tick();
        idle();
        tick();
`ifdef RETIRE_CHK_X0_FILTER_EN
        check("t6_cnt",      64'(checked_cnt), 64'd1);
        check("t6_mismatch", 64'(mismatch),    64'd0);
`else
        check("t6_mismatch", 64'(mismatch),       64'd1);
        check("t6_cause",    64'(mismatch_cause), 64'h4);
        check("t6_bad_pc",   64'(first_bad_pc),   64'h500);
`endif

        // Reset in the middle of operation discards buffered records.
        do_clear();
        for (int i = 0; i < 3; i++) begin
            ra = mk(32'h600 + 32'(i * 4), 32'h1, 1'b0, 5'd0, 32'h0);
            drive(1'b1, ra, 1'b0, ra);
            tick();
        end
        idle();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        check("t7_levels", 64'({a_level, b_level}), 64'd0);
        ra = mk(32'h700, 32'h2, 1'b1, 5'd9, 32'h99);
        drive(1'b1, ra, 1'b1, ra);
        tick();
        idle();
        tick();
        check("t7_cnt",      64'(checked_cnt), 64'd1);
        check("t7_mismatch", 64'(mismatch),    64'd0);

        // Randomized segments: both cores retire the same program with
        // independent timing; B's copy is occasionally corrupted.
        for (int s = 0; s < 30; s++) begin
            do_clear();
            for (int i = 0; i < 128; i++) prog[i] = rand_rec();
            case (s % 4)
                0:       begin pa = $urandom_range(80, 100); pb = $urandom_range(80, 100); end
                1:       begin pa = $urandom_range(0, 100);  pb = $urandom_range(0, 100);  end
                2:       begin pa = $urandom_range(1, 4);    pb = 0;                       end
                default: begin pa = 100;                     pb = $urandom_range(0, 60);   end
            endcase
            ia = 0;
            ib = 0;
            for (int c = 0; c < 120; c++) begin
                av = ($urandom_range(0, 99) < pa);
                bv = ($urandom_range(0, 99) < pb);
                ra = prog[ia];
                rb = prog[ib];
                if (bv && $urandom_range(0, 39) == 0) begin
                    case ($urandom_range(0, 5))
                        0:       rb.pc    = rb.pc ^ (32'h1 << $urandom_range(0, 31));
                        1:       rb.instr = rb.instr ^ (32'h1 << $urandom_range(0, 31));
                        2:       rb.wdata = rb.wdata ^ (32'h1 << $urandom_range(0, 31));
                        3:       rb.rd    = rb.rd ^ 5'h1;
                        4:       rb.we    = ~rb.we;
                        default: if (rb.rd == 5'd0) rb.we = ~rb.we; else rb.rd = 5'd0;
                    endcase
                end
                drive(av, ra, bv, rb);
                if (av) ia++;
                if (bv) ib++;
                tick();
            end
        end
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
